// File: rtl/draw_rect.sv
// Rectangle plotter: streams one pixel slot per clock for a W x H rectangle, column-major, fill or outline.
// First slot in the cycle after start is accepted; done pulses one cycle after the last slot; start is only heard in IDLE.
module draw_rect #(
    parameter int X_W  = 8,
    parameter int Y_W  = 7,
    parameter int SZ_W = 7,
    parameter int C_W  = 3
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [X_W-1:0]  x_in,
    input  logic [Y_W-1:0]  y_in,
    input  logic [SZ_W-1:0] w_in,
    input  logic [SZ_W-1:0] h_in,
    input  logic [C_W-1:0]  colour_in,
    input  logic            outline,
    output logic            busy,
    output logic            done,
    output logic            writeEn,
    output logic [X_W-1:0]  x_out,
    output logic [Y_W-1:0]  y_out,
    output logic [C_W-1:0]  colour_out
);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [X_W-1:0]  x0_q, x0_d;
    logic [Y_W-1:0]  y0_q, y0_d;
    logic [SZ_W-1:0] w_q, w_d;
    logic [SZ_W-1:0] h_q, h_d;
    logic [C_W-1:0]  col_q, col_d;
    logic            outl_q, outl_d;
    logic [SZ_W-1:0] cx_q, cx_d;
    logic [SZ_W-1:0] cy_q, cy_d;

    logic last_col;
    logic last_row;

    assign last_col = (cx_q == (w_q - SZ_W'(1)));
    assign last_row = (cy_q == (h_q - SZ_W'(1)));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            col_q   <= '0;
            outl_q  <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            col_q   <= col_d;
            outl_q  <= outl_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        col_d   = col_q;
        outl_d  = outl_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Zero-area requests skip straight to the done pulse without touching the latches.
                    if ((w_in != '0) && (h_in != '0)) begin
                        state_d = S_DRAW;
                        x0_d    = x_in;
                        y0_d    = y_in;
                        w_d     = w_in;
                        h_d     = h_in;
                        col_d   = colour_in;
                        outl_d  = outline;
                        cx_d    = '0;
                        cy_d    = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DRAW: begin
                if (last_row) begin
                    cy_d = '0;
                    cx_d = cx_q + SZ_W'(1);
                    if (last_col) begin
                        state_d = S_DONE;
                    end
                end else begin
                    cy_d = cy_q + SZ_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q == S_DRAW);
    assign done       = (state_q == S_DONE);
    assign writeEn    = busy && (!outl_q || (cx_q == '0) || last_col || (cy_q == '0) || last_row);
    // Coordinates wrap naturally by truncating the sum to the output width.
    assign x_out      = x0_q + X_W'(cx_q);
    assign y_out      = y0_q + Y_W'(cy_q);
    assign colour_out = col_q;

endmodule

// File: tb/tb_draw_rect.sv
// Scoreboard bench for draw_rect: a pixel-list model feeds expected writes and done times to a monitor.
module tb_draw_rect;

    localparam int X_W  = 8;
    localparam int Y_W  = 7;
    localparam int SZ_W = 7;
    localparam int C_W  = 3;

    logic            clk = 1'b0;
    logic            resetn = 1'b1;
    logic            start = 1'b0;
    logic [X_W-1:0]  x_in = '0;
    logic [Y_W-1:0]  y_in = '0;
    logic [SZ_W-1:0] w_in = '0;
    logic [SZ_W-1:0] h_in = '0;
    logic [C_W-1:0]  colour_in = '0;
    logic            outline = 1'b0;
    logic            busy, done, writeEn;
    logic [X_W-1:0]  x_out;
    logic [Y_W-1:0]  y_out;
    logic [C_W-1:0]  colour_out;

    draw_rect #(.X_W(X_W), .Y_W(Y_W), .SZ_W(SZ_W), .C_W(C_W)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .x_in(x_in), .y_in(y_in), .w_in(w_in), .h_in(h_in),
        .colour_in(colour_in), .outline(outline),
        .busy(busy), .done(done), .writeEn(writeEn),
        .x_out(x_out), .y_out(y_out), .colour_out(colour_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int x;
        int y;
        int c;
        int t;
    } pix_t;

    pix_t pq[$];
    int   dq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   busy_cnt = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: enumerate every pixel of the rectangle, keep border ones in outline mode.
    task automatic expect_rect(input int a, input int x, input int y, input int w, input int h,
                               input int c, input int o);
        pix_t p;
        if (w == 0 || h == 0) begin
            dq.push_back(a);
            return;
        end
        for (int col = 0; col < w; col++) begin
            for (int row = 0; row < h; row++) begin
                if (o == 0 || col == 0 || col == w - 1 || row == 0 || row == h - 1) begin
                    p.x = (x + col) % (1 << X_W);
                    p.y = (y + row) % (1 << Y_W);
                    p.c = c;
                    p.t = a + col * h + row;
                    pq.push_back(p);
                end
            end
        end
        dq.push_back(a + w * h);
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (writeEn) begin
                if (pq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_write: got write at (%0d,%0d) required none (cycle %0d)",
                             x_out, y_out, cyc);
                end else begin
                    pix_t p;
                    p = pq.pop_front();
                    chk("pix_x", int'(x_out), p.x);
                    chk("pix_y", int'(y_out), p.y);
                    chk("pix_colour", int'(colour_out), p.c);
                    chk("pix_cycle", cyc, p.t);
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_done: got done=1 required 0 (cycle %0d)", cyc);
                end else begin
                    chk("done_cycle", cyc, dq.pop_front());
                end
                done_cnt++;
            end
            if (busy) busy_cnt++;
        end
    end

    task automatic draw(input int x, input int y, input int w, input int h, input int c,
                        input int o, input bit hold);
        int a, d0, b0, lim;
        @(posedge clk);
        #1;
        x_in = X_W'(x); y_in = Y_W'(y); w_in = SZ_W'(w); h_in = SZ_W'(h);
        colour_in = C_W'(c); outline = o[0];
        start = 1'b1;
        @(posedge clk);
        #1;
        a  = cyc;
        d0 = done_cnt;
        b0 = busy_cnt;
        expect_rect(a, x, y, w, h, c, o);
        if (!hold) begin
            start = 1'b0;
            x_in = X_W'($urandom); y_in = Y_W'($urandom); w_in = SZ_W'($urandom);
            h_in = SZ_W'($urandom); colour_in = C_W'($urandom); outline = 1'($urandom);
        end
        lim = w * h + 8;
        while (done_cnt == d0 && lim > 0) begin
            @(negedge clk);
            #1;
            lim--;
            if (hold) begin
                x_in = X_W'($urandom);
                y_in = Y_W'($urandom);
            end
        end
        start = 1'b0;
        if (done_cnt == d0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: got no done within %0d cycles required one", w * h + 8);
        end
        chk("busy_cycles", busy_cnt - b0, w * h);
        chk("writes_outstanding", pq.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        #2 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_writeEn", int'(writeEn), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_x_out", int'(x_out), 0);
        chk("rst_y_out", int'(y_out), 0);
        chk("rst_colour_out", int'(colour_out), 0);
        resetn = 1'b1;

        draw(10, 20, 3, 2, 5, 0, 1'b0);
        draw(0, 0, 4, 4, 1, 1, 1'b0);
        draw(7, 9, 0, 5, 2, 0, 1'b0);
        draw(254, 126, 4, 3, 3, 0, 1'b0);
        draw(50, 60, 3, 3, 4, 0, 1'b1);
        draw(51, 61, 2, 2, 6, 1, 1'b0);

        // Abort a 5x5 draw after its fourth pixel with an asynchronous reset.
        @(posedge clk);
        #1;
        x_in = 8'd30; y_in = 7'd40; w_in = 7'd5; h_in = 7'd5; colour_in = 3'd6; outline = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = cyc;
        start = 1'b0;
        expect_rect(a, 30, 40, 5, 5, 6, 0);
        repeat (4) @(negedge clk);
        #2;
        pq.delete();
        dq.delete();
        resetn = 1'b0;
        #1;
        chk("abort_writeEn", int'(writeEn), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_x_out", int'(x_out), 0);
        chk("abort_y_out", int'(y_out), 0);
        @(posedge clk);
        @(posedge clk);
        #2 resetn = 1'b1;
        draw(30, 40, 5, 5, 6, 0, 1'b0);

        draw(100, 10, 1, 5, 7, 1, 1'b0);
        draw(100, 10, 5, 1, 2, 1, 1'b0);
        draw(3, 3, 5, 0, 1, 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int w, h;
            w = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
            h = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
            if ($urandom_range(0, 9) == 0) w = $urandom_range(7, 20);
            draw($urandom_range(0, 255), $urandom_range(0, 127), w, h,
                 $urandom_range(0, 7), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
